// File: rtl/channel_isi_prl.sv
// PAM4 channel model: Gray symbol to level mapping, then a serial
// one-MAC-per-clock convolution with a programmable pulse response.
module channel_isi_prl #(
    parameter int PULSE_RESPONSE_LENGTH = 5,
    parameter int SIGNAL_RESOLUTION     = 8,
    parameter int SYMBOL_SEPERATION     = 56,
    parameter int COEF_WIDTH            = 8,
    parameter int COEF_FRAC             = 6
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic [1:0]                           sym_in,
    input  logic                                 sym_in_valid,
    output logic                                 sym_in_ready,
    input  logic                                 coef_wr_en,
    input  logic [$clog2(PULSE_RESPONSE_LENGTH)-1:0] coef_wr_addr,
    input  logic [COEF_WIDTH-1:0]                coef_wr_data,
    output logic signed [SIGNAL_RESOLUTION-1:0]  signal_out,
    output logic                                 signal_out_valid,
    output logic                                 sat_flag
);

    localparam int L    = PULSE_RESPONSE_LENGTH;
    localparam int SR   = SIGNAL_RESOLUTION;
    localparam int CW   = COEF_WIDTH;
    localparam int AW   = $clog2(L);
    localparam int LW   = SR + 1;
    localparam int ACCW = LW + CW + AW;

    localparam logic signed [LW-1:0]   LV1  = LW'(SYMBOL_SEPERATION / 2);
    localparam logic signed [LW-1:0]   LV3  = LW'((3 * SYMBOL_SEPERATION) / 2);
    localparam logic signed [ACCW-1:0] HALF = ACCW'(2 ** (COEF_FRAC - 1));
    localparam logic signed [ACCW-1:0] RMAX = ACCW'((2 ** (SR - 1)) - 1);
    localparam logic signed [ACCW-1:0] RMIN = -ACCW'(2 ** (SR - 1));
    localparam logic [AW-1:0]          LAST = AW'(L - 1);
    localparam logic [AW:0]            LEN  = (AW + 1)'(L);
    localparam logic signed [CW-1:0]   ONE  = CW'(2 ** COEF_FRAC);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        OUT
    } state_t;

    state_t                  state;
    logic signed [LW-1:0]    hist [L];
    logic signed [CW-1:0]    coef [L];
    logic signed [ACCW-1:0]  acc;
    logic [AW-1:0]           tap;

    logic signed [LW-1:0]    lvl;
    logic signed [ACCW-1:0]  h_ext;
    logic signed [ACCW-1:0]  c_ext;
    logic signed [ACCW-1:0]  prod;
    logic signed [ACCW-1:0]  rnd;
    logic                    wr_ok;

    assign sym_in_ready = (state == IDLE);
    assign wr_ok = coef_wr_en && ({1'b0, coef_wr_addr} < LEN);

    always_comb begin
        lvl = -LV3;
        unique case (sym_in)
            2'b00: lvl = -LV3;
            2'b01: lvl = -LV1;
            2'b11: lvl = LV1;
            2'b10: lvl = LV3;
        endcase
    end

    assign h_ext = ACCW'(hist[tap]);
    assign c_ext = ACCW'(coef[tap]);
    assign prod  = h_ext * c_ext;
    assign rnd   = (acc + HALF) >>> COEF_FRAC;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state            <= IDLE;
            acc              <= '0;
            tap              <= '0;
            signal_out       <= '0;
            signal_out_valid <= 1'b0;
            sat_flag         <= 1'b0;
            for (int k = 0; k < L; k++) begin
                hist[k] <= '0;
                coef[k] <= (k == 0) ? ONE : '0;
            end
        end else begin
            signal_out_valid <= 1'b0;
            sat_flag         <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (wr_ok)
                        coef[coef_wr_addr] <= coef_wr_data;
                    if (sym_in_valid) begin
                        for (int k = L - 1; k > 0; k--)
                            hist[k] <= hist[k-1];
                        hist[0] <= lvl;
                        acc     <= '0;
                        tap     <= '0;
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + prod;
                    tap <= tap + AW'(1);
                    if (tap == LAST)
                        state <= OUT;
                end
                OUT: begin
                    signal_out_valid <= 1'b1;
                    if (rnd > RMAX) begin
                        signal_out <= RMAX[SR-1:0];
                        sat_flag   <= 1'b1;
                    end else if (rnd < RMIN) begin
                        signal_out <= RMIN[SR-1:0];
                        sat_flag   <= 1'b1;
                    end else begin
                        signal_out <= rnd[SR-1:0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_isi_prl.sv
// Bench for channel_isi_prl: convolution model checked every cycle,
// plus directed literal expectations.
module tb_channel_isi_prl;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [1:0]        sym_in = 2'b00;
    logic              sym_in_valid = 1'b0;
    logic              sym_in_ready;
    logic              coef_wr_en = 1'b0;
    logic [2:0]        coef_wr_addr = 3'd0;
    logic [7:0]        coef_wr_data = 8'd0;
    logic signed [7:0] signal_out;
    logic              signal_out_valid;
    logic              sat_flag;

    channel_isi_prl dut (
        .clk              (clk),
        .rstn             (rstn),
        .sym_in           (sym_in),
        .sym_in_valid     (sym_in_valid),
        .sym_in_ready     (sym_in_ready),
        .coef_wr_en       (coef_wr_en),
        .coef_wr_addr     (coef_wr_addr),
        .coef_wr_data     (coef_wr_data),
        .signal_out       (signal_out),
        .signal_out_valid (signal_out_valid),
        .sat_flag         (sat_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: symbol history, coefficients, pending outputs
    typedef struct {
        int due;
        int val;
        int sat;
    } exp_t;

    int   m_coef [5];
    int   m_hist [5];
    int   busy = 0;
    int   cyc = 0;
    bit   acc_flag = 0;
    int   acc_cyc = 0;
    int   m_last = 0;
    exp_t q [$];

    function automatic int level(input logic [1:0] s);
        case (s)
            2'b00:   return -84;
            2'b01:   return -28;
            2'b11:   return 28;
            default: return 84;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            acc_flag = 0;
            if (!rstn) begin
                for (int k = 0; k < 5; k++) begin
                    m_hist[k] = 0;
                    m_coef[k] = (k == 0) ? 64 : 0;
                end
                busy   = 0;
                m_last = 0;
                q.delete();
            end else if (busy == 0) begin
                if (coef_wr_en && coef_wr_addr < 3'd5)
                    m_coef[coef_wr_addr] = int'($signed(coef_wr_data));
                if (sym_in_valid) begin
                    int sum;
                    int r;
                    exp_t e;
                    for (int k = 4; k > 0; k--)
                        m_hist[k] = m_hist[k-1];
                    m_hist[0] = level(sym_in);
                    sum = 0;
                    for (int k = 0; k < 5; k++)
                        sum += m_hist[k] * m_coef[k];
                    r = (sum + 32) >>> 6;
                    e.due = cyc + 6;
                    e.sat = (r > 127 || r < -128) ? 1 : 0;
                    e.val = (r > 127) ? 127 : (r < -128) ? -128 : r;
                    q.push_back(e);
                    busy     = 6;
                    acc_flag = 1;
                    acc_cyc  = cyc;
                end
            end else begin
                busy--;
            end
            @(negedge clk);
            check("ready", int'(sym_in_ready), (busy == 0) ? 1 : 0);
            if (q.size() > 0 && q[0].due == cyc) begin
                check("valid", int'(signal_out_valid), 1);
                check("value", int'(signal_out), q[0].val);
                check("sat", int'(sat_flag), q[0].sat);
                m_last = q[0].val;
                void'(q.pop_front());
            end else begin
                check("no_valid", int'(signal_out_valid), 0);
                check("no_sat", int'(sat_flag), 0);
                check("hold", int'(signal_out), m_last);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic wr(input int a, input int d);
        @(negedge clk);
        coef_wr_en   = 1'b1;
        coef_wr_addr = 3'(a);
        coef_wr_data = 8'(d);
        @(negedge clk);
        coef_wr_en = 1'b0;
    endtask

    task automatic send(input logic [1:0] s, input int lit, input int lsat,
                        input bit we = 0, input int wa = 0, input int wd = 0);
        int lat;
        bit got;
        @(negedge clk);
        sym_in       = s;
        sym_in_valid = 1'b1;
        coef_wr_en   = we;
        coef_wr_addr = 3'(wa);
        coef_wr_data = 8'(wd);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = acc_flag;
        end
        sym_in_valid = 1'b0;
        coef_wr_en   = 1'b0;
        check("accept", int'(got), 1);
        lat = 0;
        got = 0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            lat++;
            got = signal_out_valid;
        end
        check("out_seen", int'(got), 1);
        check("latency", lat, 6);
        check("lit_val", int'(signal_out), lit);
        check("lit_sat", int'(sat_flag), lsat);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int accs [$];
        int outs;
        do_reset();
        check("rst_out", int'(signal_out), 0);
        check("rst_ready", int'(sym_in_ready), 1);

        send(2'b10, 84, 0);
        send(2'b00, -84, 0);

        do_reset();
        wr(0, 64);
        wr(1, 32);
        wr(2, 16);
        send(2'b11, 28, 0);
        send(2'b11, 42, 0);
        send(2'b11, 49, 0);

        do_reset();
        wr(1, 64);
        send(2'b10, 84, 0);
        send(2'b10, 127, 1);
        send(2'b00, 0, 0);
        send(2'b00, -128, 1);

        do_reset();
        wr(0, 40);
        send(2'b01, -17, 0);
        send(2'b11, 18, 0);
        wr(6, 64);
        send(2'b10, 84, 0, 1, 0, 64);

        do_reset();
        @(negedge clk);
        sym_in       = 2'b11;
        sym_in_valid = 1'b1;
        outs = 0;
        for (int i = 0; i < 40 && outs < 3; i++) begin
            @(negedge clk);
            coef_wr_en = 1'b0;
            if (acc_flag) begin
                accs.push_back(acc_cyc);
                if (accs.size() == 1) begin
                    coef_wr_en   = 1'b1;
                    coef_wr_addr = 3'd0;
                    coef_wr_data = 8'd0;
                end
                if (accs.size() == 3)
                    sym_in_valid = 1'b0;
            end
            if (signal_out_valid) begin
                outs++;
                check("flow_val", int'(signal_out), 28);
            end
        end
        sym_in_valid = 1'b0;
        coef_wr_en   = 1'b0;
        check("flow_outs", outs, 3);
        check("flow_accs", accs.size(), 3);
        if (accs.size() == 3) begin
            check("spacing1", accs[1] - accs[0], 7);
            check("spacing2", accs[2] - accs[1], 7);
        end

        @(negedge clk);
        sym_in       = 2'b10;
        sym_in_valid = 1'b1;
        @(negedge clk);
        sym_in_valid = 1'b0;
        check("mid_accept", int'(acc_flag), 1);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++)
            @(negedge clk);
        check("mid_ready", int'(sym_in_ready), 1);
        wr(1, 64);
        send(2'b11, 28, 0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
